// File: rtl/ram_capture_writer_if.sv
// Capture-request, receive-handshake and RAM-write bundle for ram_capture_writer.
// The abort line exists only when CAPTURE_ABORT_EN is defined.
interface ram_capture_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] words_written;
`ifdef CAPTURE_ABORT_EN
  logic              abort;
`endif

  modport master (
    output start, base_addr, word_count, in_valid, in_data,
`ifdef CAPTURE_ABORT_EN
    output abort,
`endif
    input  in_ready, ram_we, ram_addr, ram_wdata, busy, done, words_written
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
`ifdef CAPTURE_ABORT_EN
    input  abort,
`endif
    output in_ready, ram_we, ram_addr, ram_wdata, busy, done, words_written
  );
endinterface

// File: rtl/ram_capture_writer.sv
// Buffers a length-bounded burst through a small FIFO and writes it to consecutive RAM addresses.
// Accept-to-write latency 2 edges; in_ready drops when FIFO full or count reached. Option: CAPTURE_ABORT_EN.
module ram_capture_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_capture_writer_if.slave  io_cap
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_accepted;
  logic [ADDR_W-1:0] r_written;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fill;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  logic w_abort;
  logic w_full;
  logic w_empty;
  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_start_acc;
  logic w_flush;

`ifdef CAPTURE_ABORT_EN
  assign w_abort = io_cap.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Flags come from the registered fill level, so a full FIFO never passes data through.
  assign w_full  = (r_fill == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_fill == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_start_acc = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_cap.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (io_cap.word_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_in_ready = !w_full && (r_accepted < r_count);
          w_push     = w_in_ready && io_cap.in_valid;
          w_pop      = !w_empty;
          if (w_pop && ((r_written + ADDR_W'(1)) == r_count)) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_cap.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_accepted  <= '0;
      r_written   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= w_pop;
      if (w_start_acc) begin
        r_base     <= io_cap.base_addr;
        r_count    <= io_cap.word_count;
        r_accepted <= '0;
        r_written  <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fill     <= '0;
      end else if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_fill   <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
          r_accepted <= r_accepted + ADDR_W'(1);
        end
        if (w_pop) begin
          // Address arithmetic wraps naturally at 2^ADDR_W.
          r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
          r_ram_addr  <= r_base + r_written;
          r_ram_wdata <= r_mem[r_rd_ptr];
          r_written   <= r_written + ADDR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_fill <= r_fill + CNT_W'(1);
          2'b01:   r_fill <= r_fill - CNT_W'(1);
          default: r_fill <= r_fill;
        endcase
      end
    end
  end

  assign io_cap.in_ready      = w_in_ready;
  assign io_cap.ram_we        = r_ram_we;
  assign io_cap.ram_addr      = r_ram_addr;
  assign io_cap.ram_wdata     = r_ram_wdata;
  assign io_cap.busy          = (r_state != S_IDLE);
  assign io_cap.done          = (r_state == S_DONE);
  assign io_cap.words_written = r_written;
endmodule
